// File: rtl/ram_arb_4p.sv
// ram_arb_4p: four-port arbiter/sequencer sharing one single-port RAM (round-robin by default).
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 highest) instead of round-robin.
module ram_arb_4p #(
  parameter int addr_size = 10,
  parameter int word_size = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             req,
  input  logic [3:0]             wr,
  input  logic [4*addr_size-1:0] addr,
  input  logic [4*word_size-1:0] wdata,
  output logic [3:0]             ack,
  output logic [4*word_size-1:0] rdata,
  output logic                   ram_cs,
  output logic                   ram_wr,
  output logic [addr_size-1:0]   ram_addr,
  output logic [word_size-1:0]   ram_wdata,
  input  logic [word_size-1:0]   ram_rdata,
  output logic                   busy,
  output logic [1:0]             grant_id
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state_q, state_d;
  logic cs_q, cs_d, wr_q, wr_d, done, found;
  logic [addr_size-1:0] addr_q, addr_d;
  logic [word_size-1:0] wdata_q, wdata_d;
  logic [4*word_size-1:0] rdata_q, rdata_d;
  logic [3:0] ack_q, ack_d, mask, elig, rot;
  logic [1:0] gid_q, gid_d, base, off, win;
`ifdef RAM_ARB_FIXED_PRIO_EN
  assign base = 2'd0;
`else
  logic [1:0] ptr_q, ptr_d;
  assign base = ptr_q;
  assign ptr_d = found ? win + 2'd1 : ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= 2'd0;
    else ptr_q <= ptr_d;
`endif
  // The port completing at this edge is masked so it cannot win twice in a row.
  always_comb begin
    done = state_q == ACCESS;
    mask = done ? 4'b1 << gid_q : 4'b0;
    elig = req & ~mask;
    rot = 4'({elig, elig} >> base);
    found = |elig;
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    win = base + off;
    state_d = found ? ACCESS : IDLE;
    cs_d = found;
    wr_d = found & wr[win];
    addr_d = found ? addr[win*addr_size +: addr_size] : addr_q;
    wdata_d = found ? wdata[win*word_size +: word_size] : wdata_q;
    gid_d = found ? win : 2'd0;
    ack_d = mask;
    rdata_d = rdata_q;
    if (done && !wr_q) rdata_d[gid_q*word_size +: word_size] = ram_rdata;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cs_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q <= '0;
      gid_q <= '0;
    end else begin
      state_q <= state_d;
      cs_q <= cs_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q <= ack_d;
      gid_q <= gid_d;
    end
  assign ack = ack_q;
  assign rdata = rdata_q;
  assign ram_cs = cs_q;
  assign ram_wr = wr_q;
  assign ram_addr = addr_q;
  assign ram_wdata = wdata_q;
  assign busy = cs_q;
  assign grant_id = gid_q;
endmodule

// File: tb/tb_ram_arb_4p.sv
// tb_ram_arb_4p: directed and randomized checks of ram_arb_4p against a transaction-level model.
module tb_ram_arb_4p;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req_v = '0, wr_v = '0;
  logic [39:0] addr_v = '0;
  logic [31:0] wdata_v = '0;
  logic [3:0] ack;
  logic [31:0] rdata;
  logic ram_cs, ram_wr, busy;
  logic [9:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  logic [1:0] grant_id;
  logic [7:0] ram [1024];
  logic [7:0] mem_ref [1024];
  int errors = 0, checks = 0;
  bit m_busy, m_wr;
  int m_g, m_ptr, m_addr;
  logic [7:0] m_wd;
  logic [3:0] m_ack;
  logic [31:0] m_rd;

  ram_arb_4p #(.addr_size(10), .word_size(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req_v), .wr(wr_v), .addr(addr_v), .wdata(wdata_v),
    .ack(ack), .rdata(rdata), .ram_cs(ram_cs), .ram_wr(ram_wr), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  assign ram_rdata = ram[ram_addr];
  always @(posedge clk) if (ram_cs && ram_wr) ram[ram_addr] <= ram_wdata;

  task automatic model_reset();
    m_busy = 0; m_wr = 0; m_g = 0; m_ptr = 0; m_addr = 0; m_wd = '0; m_ack = '0; m_rd = '0;
  endtask

  // Transaction view: a granted access completes one edge later; the completing port sits out one pick.
  task automatic model_edge();
    int w = -1;
    logic [3:0] e;
    m_ack = m_busy ? 4'(1 << m_g) : 4'b0;
    if (m_busy && m_wr) mem_ref[m_addr] = m_wd;
    if (m_busy && !m_wr) m_rd[m_g*8 +: 8] = mem_ref[m_addr];
    e = req_v & ~m_ack;
    for (int i = 0; i < 4; i++) if (w < 0 && e[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
    m_busy = w >= 0;
    m_g = w >= 0 ? w : 0;
    if (w >= 0) begin
      m_wr = wr_v[w]; m_addr = int'(addr_v[w*10 +: 10]); m_wd = wdata_v[w*8 +: 8];
`ifndef RAM_ARB_FIXED_PRIO_EN
      m_ptr = (w + 1) % 4;
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic set_port(input int k, input logic r, input logic w, input logic [9:0] a, input logic [7:0] d);
    req_v[k] = r; wr_v[k] = w; addr_v[k*10 +: 10] = a; wdata_v[k*8 +: 8] = d;
  endtask

  task automatic release_acked();
    req_v = req_v & ~m_ack;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    model_reset();
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) set_port(k, 1, 1, 10'(k), 8'(k + 1));
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({ack, rdata, ram_cs, ram_wr, ram_addr, ram_wdata, busy, grant_id} !== '0) begin
        errors++; $display("FAIL reset_outputs: got ack=%h rdata=%h cs=%b gid=%0d want all 0", ack, rdata, ram_cs, grant_id);
      end
    end
    req_v = '0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_port();
    set_port(2, 1, 1, 10'h012, 8'hA5);
    step();
    checks++;
    if ({ram_cs, ram_wr, grant_id, ram_addr, ram_wdata, ack} !== {1'b1, 1'b1, 2'd2, 10'h012, 8'hA5, 4'b0}) begin
      errors++; $display("FAIL single_write_issue: cs=%b wr=%b gid=%0d addr=%h wd=%h ack=%b want 1 1 2 012 a5 0000", ram_cs, ram_wr, grant_id, ram_addr, ram_wdata, ack);
    end
    step();
    checks++;
    if (ack !== 4'b0100) begin errors++; $display("FAIL single_write_ack: got %b want 0100", ack); end
    set_port(2, 1, 0, 10'h012, 8'h00);
    step();
    checks++;
    if ({ram_cs, ram_wr, grant_id, ack} !== {1'b1, 1'b0, 2'd2, 4'b0}) begin
      errors++; $display("FAIL single_read_issue: cs=%b wr=%b gid=%0d ack=%b want 1 0 2 0000", ram_cs, ram_wr, grant_id, ack);
    end
    step();
    checks++;
    if (ack !== 4'b0100 || rdata[23:16] !== 8'hA5) begin
      errors++; $display("FAIL single_read_data: ack=%b rdata2=%h want 0100 a5", ack, rdata[23:16]);
    end
    release_acked();
    step();
    checks++;
    if (ram_cs !== 1'b0 || ack !== 4'b0) begin errors++; $display("FAIL single_idle: cs=%b ack=%b want 0 0000", ram_cs, ack); end
  endtask

  task automatic test_all_four();
    hold_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 4; k++) set_port(k, 1, pass == 0, 10'(k), 8'(8'h10 + k));
      for (int i = 0; i < 4; i++) begin
        step();
        checks++;
        if (grant_id !== 2'(i) || ram_cs !== 1'b1 || ack !== (i == 0 ? 4'b0 : 4'b1 << (i - 1))) begin
          errors++; $display("FAIL four_grant%0d_pass%0d: gid=%0d cs=%b ack=%b want %0d 1", i, pass, grant_id, ram_cs, ack, i);
        end
        release_acked();
      end
      step();
      checks++;
      if (ack !== 4'b1000 || ram_cs !== 1'b0) begin errors++; $display("FAIL four_last_ack_pass%0d: ack=%b cs=%b want 1000 0", pass, ack, ram_cs); end
      release_acked();
    end
    checks++;
    if (rdata !== 32'h13121110) begin errors++; $display("FAIL four_readback: got %h want 13121110", rdata); end
  endtask

  task automatic test_no_starve();
    int exp_g[5] = '{1, 3, 1, -1, 1};
    set_port(1, 1, 0, 10'h005, 8'h00);
    set_port(3, 1, 1, 10'h006, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (exp_g[i] < 0 ? ram_cs !== 1'b0 : (ram_cs !== 1'b1 || grant_id !== 2'(exp_g[i]))) begin
        errors++; $display("FAIL rr_step%0d: cs=%b gid=%0d want grant %0d", i, ram_cs, grant_id, exp_g[i]);
      end
      if (m_ack[3]) req_v[3] = 1'b0;
    end
    req_v[1] = 1'b0;
    step(); step();
  endtask

  task automatic test_last_addr();
    hold_reset();
    set_port(2, 1, 1, 10'h3FF, 8'hFF);
    step(); step();
    release_acked();
    set_port(0, 1, 0, 10'h3FF, 8'h00);
    set_port(1, 1, 1, 10'h3FF, 8'h00);
    step();
    checks++;
    if (grant_id !== 2'd0 || ram_cs !== 1'b1) begin errors++; $display("FAIL last_first_grant: gid=%0d cs=%b want 0 1", grant_id, ram_cs); end
    step();
    checks++;
    if (grant_id !== 2'd1 || rdata[7:0] !== 8'hFF || ack !== 4'b0001) begin
      errors++; $display("FAIL last_read_ff: gid=%0d rdata0=%h ack=%b want 1 ff 0001", grant_id, rdata[7:0], ack);
    end
    release_acked();
    step();
    release_acked();
    set_port(0, 1, 0, 10'h3FF, 8'h00);
    step(); step();
    checks++;
    if (rdata[7:0] !== 8'h00 || ack !== 4'b0001) begin errors++; $display("FAIL last_read_00: rdata0=%h ack=%b want 00 0001", rdata[7:0], ack); end
    release_acked();
    step();
  endtask

  task automatic test_reset_mid_access();
    set_port(3, 1, 1, 10'h055, 8'h33);
    step(); step();
    release_acked();
    set_port(3, 1, 1, 10'h055, 8'h77);
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({ack, rdata, ram_cs, ram_wr, ram_addr, ram_wdata, busy, grant_id} !== '0) begin
      errors++; $display("FAIL midreset_async: cs=%b wr=%b gid=%0d ack=%b want all 0", ram_cs, ram_wr, grant_id, ack);
    end
    step();
    checks++;
    if (ack !== 4'b0 || ram_cs !== 1'b0) begin errors++; $display("FAIL midreset_no_ack: ack=%b cs=%b want 0000 0", ack, ram_cs); end
    req_v[3] = 1'b0;
    rst_n = 1'b1;
    step();
    set_port(3, 1, 0, 10'h055, 8'h00);
    step(); step();
    checks++;
    if (ack !== 4'b1000 || rdata[31:24] !== 8'h33) begin errors++; $display("FAIL midreset_old_value: ack=%b rdata3=%h want 1000 33", ack, rdata[31:24]); end
    release_acked();
    step();
  endtask

  task automatic test_prio_0_over_3();
    hold_reset();
    set_port(3, 1, 1, 10'h100, 8'hC3);
    set_port(0, 1, 1, 10'h101, 8'h3C);
    step();
    checks++;
    if (grant_id !== 2'd0 || ram_cs !== 1'b1) begin errors++; $display("FAIL prio_first: gid=%0d want 0", grant_id); end
    step();
    checks++;
    if (grant_id !== 2'd3 || ack !== 4'b0001) begin errors++; $display("FAIL prio_second: gid=%0d ack=%b want 3 0001", grant_id, ack); end
    release_acked();
    step();
    checks++;
    if (ack !== 4'b1000) begin errors++; $display("FAIL prio_ack3: ack=%b want 1000", ack); end
    release_acked();
    step();
  endtask

  task automatic test_random();
    int wait_cnt[4] = '{0, 0, 0, 0};
    logic [9:0] a;
    for (int c = 0; c < 600; c++) begin
      step();
      checks++;
      if (ram_cs !== m_busy || busy !== m_busy || grant_id !== 2'(m_g)) begin
        errors++; $display("FAIL rand_grant c%0d: cs=%b busy=%b gid=%0d want %b %0d", c, ram_cs, busy, grant_id, m_busy, m_g);
      end
      checks++;
      if (ack !== m_ack) begin errors++; $display("FAIL rand_ack c%0d: got %b want %b", c, ack, m_ack); end
      checks++;
      if (rdata !== m_rd) begin errors++; $display("FAIL rand_rdata c%0d: got %h want %h", c, rdata, m_rd); end
      if (m_busy) begin
        checks++;
        if (ram_wr !== m_wr || ram_addr !== 10'(m_addr) || (m_wr && ram_wdata !== m_wd)) begin
          errors++; $display("FAIL rand_cmd c%0d: wr=%b addr=%h wd=%h want %b %h %h", c, ram_wr, ram_addr, ram_wdata, m_wr, m_addr, m_wd);
        end
      end else begin
        checks++;
        if (ram_wr !== 1'b0) begin errors++; $display("FAIL rand_idle_wr c%0d: got %b want 0", c, ram_wr); end
      end
      for (int k = 0; k < 4; k++) begin
        if (ack[k]) wait_cnt[k] = 0;
        else if (req_v[k]) wait_cnt[k]++;
        if (req_v[k]) begin
          checks++;
          if (wait_cnt[k] > 8) begin errors++; $display("FAIL rand_starve c%0d port%0d: waited %0d want <=8", c, k, wait_cnt[k]); end
        end
      end
      for (int k = 0; k < 4; k++) begin
        a = ($urandom_range(0, 9) == 0) ? 10'h3FF : 10'($urandom_range(0, 7));
        if (m_ack[k]) begin
          if ($urandom_range(0, 1) == 1) set_port(k, 1, 1'($urandom_range(0, 1)), a, 8'($urandom));
          else req_v[k] = 1'b0;
        end else if (!req_v[k] && $urandom_range(0, 2) == 0) begin
          set_port(k, 1, 1'($urandom_range(0, 1)), a, 8'($urandom));
        end
      end
    end
    req_v = '0;
    step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin ram[i] = 8'h00; mem_ref[i] = 8'h00; end
    model_reset();
    test_reset();
    test_single_port();
    test_all_four();
    test_no_starve();
    test_last_addr();
    test_reset_mid_access();
    test_prio_0_over_3();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_arb_4p.md
# ram_arb_4p

Four-port round-robin arbiter and sequencer that shares one single-port synchronous-write / combinational-read RAM (`clk`, `wr`, `cs`, `addr`, `data_in`, `data_out`) among four independent requesters. Each requester issues a read or write with a req/ack handshake. The arbiter registers the winning command onto the RAM pins, captures read data, and returns a one-cycle ack. It is the front end that turns the single-port array into the 4-port memory.

## Interface
Parameters:
- `addr_size`, 10: RAM address width.
- `word_size`, 8: RAM data width.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  per-port request; bit k belongs to port k.
- `wr`  in  4  per-port direction; 1 = write, 0 = read. Valid while `req[k]` = 1.
- `addr`  in  4*addr_size  per-port address; port k occupies slice [k*addr_size +: addr_size].
- `wdata`  in  4*word_size  per-port write data; port k occupies slice [k*word_size +: word_size].
- `ack`  out  4  one-cycle completion pulse per port.
- `rdata`  out  4*word_size  per-port read data, registered. Valid in the `ack` cycle of a read and held afterwards.
- `ram_cs`, `ram_wr`  out  1 each  registered RAM controls.
- `ram_addr`  out  addr_size  registered RAM address.
- `ram_wdata`  out  word_size  registered RAM write data.
- `ram_rdata`  in  word_size  RAM combinational read data.
- `busy`  out  1  high while an access occupies the RAM (equals `ram_cs`).
- `grant_id`  out  2  index of the port currently on the RAM; 0 when idle.

## Operation
- Handshake:
  - The requester raises `req[k]` and holds `wr`, `addr` and `wdata` stable until it sees `ack[k]`.
  - `req[k]` still high on the edge after the `ack[k]` cycle is a new request.
- FSM has two states:
  - IDLE: no access in flight.
  - ACCESS: one command is on the RAM pins.
- At each edge, while in IDLE or completing an ACCESS, the arbiter picks a winner from the eligible requests:
  - Eligible = `req` with the bit of the port completing at this same edge masked off.
  - Winner exists: load `ram_cs`=1, `ram_wr`/`ram_addr`/`ram_wdata` from the winner's fields, and `grant_id`=winner. Go to (or stay in) ACCESS.
  - No winner: `ram_cs`=0, `ram_wr`=0, `grant_id`=0. Go to IDLE.
- Completion edge of ACCESS for port g:
  - `ack[g]`=1 for exactly one cycle.
  - If the access was a read, the `rdata` slice for g is loaded from `ram_rdata`.
  - Writes commit in the RAM at this same edge.
- `rdata` slices change only on read completion for their own port.
- Round-robin:
  - The 2-bit pointer `ptr` resets to 0.
  - The search starts at `ptr` and proceeds ptr, ptr+1, ... modulo 4.
  - After a grant to port k, `ptr` = (k+1) mod 4.
- Reset:
  - While `rst_n`=0, all outputs are 0, `ptr`=0, and the FSM is in IDLE.
  - Assertion mid-access clears `ram_cs` immediately, so the in-flight write is not committed and no ack is issued.
  - After release, requesters with `req` still high are re-arbitrated normally.

## Timing
- Latency: `req[k]` high before edge E0, with k winning at E0:
  - `ram_cs`=1 during E0–E1.
  - `ack[k]`, and `rdata` for a read, valid during E1–E2.
- Throughput: back-to-back accesses from different ports give one access per cycle.
- A single port requesting continuously gets one access per two cycles, because of the mask at its completion edge.
- Starvation bound: a waiting port is granted within 4 accesses.
- `ram_wr`=1 always comes with `ram_cs`=1. Reads present `ram_cs`=1, `ram_wr`=0, which matches the RAM's read condition.

## Configuration
- `RAM_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, port 0 highest and port 3 lowest. `ptr` is removed. The completion-edge mask still applies, so port 0 cannot lock out others on consecutive cycles.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset, then port 2 writes 0xA5 to addr 0x012. Then port 2 reads addr 0x012 → `ram_cs` one cycle after `req`, `ack[2]` one cycle later, `rdata[2]`=0xA5.
- All four ports request writes of 0x10, 0x11, 0x12, 0x13 to addr 0x000–0x003 simultaneously from reset → grants in order 0,1,2,3 on consecutive cycles, one `ack` per cycle. Reads return the same values.
- Port 1 holds `req` high continuously while port 3 requests once → grants alternate 1,3,1 and port 3 is not starved.
- Port 0 read of 0x3FF (last address) containing 0xFF while port 1 writes 0x00 to 0x3FF in the next grant → `rdata[0]`=0xFF, and a later read returns 0x00.
- `rst_n` pulled low during the ACCESS cycle of a port 3 write of 0x77 to 0x055 → no `ack[3]`, a later read of 0x055 returns the old value, and all outputs are 0 during reset.
- With `RAM_ARB_FIXED_PRIO_EN` defined, ports 3 and 0 request together → port 0 is granted first, then port 3.
